// File: rtl/zeroheti_pkg.sv
// zeroHETI shared definitions: address map entry for the machine timer window,
// its register offsets, control register layout and a byte-enable merge helper.
package zeroheti_pkg;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] last;
  } addr_rule_t;

  localparam addr_rule_t MtimerAddr = '{base: 32'h0000_2100, last: 32'h0000_2114};

  localparam logic [31:0] MtimeLoOffs    = 32'h00;
  localparam logic [31:0] MtimeHiOffs    = 32'h04;
  localparam logic [31:0] MtimeCmpLoOffs = 32'h08;
  localparam logic [31:0] MtimeCmpHiOffs = 32'h0C;
  localparam logic [31:0] MtimeCtrlOffs  = 32'h10;

  // PRESC lives in CTRL[31:8], so 24 bits is the widest it can ever be.
  localparam int unsigned MtimerPrescMaxW = 24;

  typedef struct packed {
    logic [MtimerPrescMaxW-1:0] presc;
    logic                       en;
  } mtimer_ctrl_t;

  localparam logic [63:0] MtimeCmpRst = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/zeroheti_mtimer_presc.sv
// mtime prescaler: counts while EN is set, emits a one-cycle tick when the count
// equals PRESC and wraps to 0; count freezes while EN is low, clears on i_clr.
module zeroheti_mtimer_presc #(
  parameter int unsigned PrescW = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              i_en,
  input  logic [PrescW-1:0] i_presc,
  input  logic              i_clr,
  output logic              o_tick
);

  logic [PrescW-1:0] r_cnt;
  logic              w_hit;

  assign w_hit  = (r_cnt == i_presc);
  assign o_tick = i_en && w_hit;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_hit ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/zeroheti_mtimer.sv
// RISC-V machine timer OBI responder (1-cycle response, gnt_o = req_i).
// Optional MTIMER_ATOMIC_READ_EN: MTIME_LO read latches mtime[63:32] for a tear-free HI read.
module zeroheti_mtimer
  import zeroheti_pkg::*;
#(
  parameter logic [31:0] BaseAddr = MtimerAddr.base,
  parameter int unsigned PrescW   = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        timer_irq_o
);

  logic [63:0]  r_mtime;
  logic [63:0]  r_mtimecmp;
  mtimer_ctrl_t r_ctrl;
  logic         r_rvalid;
  logic [31:0]  r_rdata;
  logic         r_err;
  logic         r_irq;

  logic [31:0] w_offs;
  logic [29:0] w_word;
  logic        w_hit, w_wr, w_rd, w_be_any, w_tick;
  logic        w_sel_mlo, w_sel_mhi, w_sel_clo, w_sel_chi, w_sel_ctrl;
  logic        w_mtime_wr, w_ctrl_clr;
  logic [31:0] w_ctrl_rd, w_mtime_hi_rd, w_rdata;

  assign gnt_o  = req_i;
  assign w_offs = addr_i - BaseAddr;
  assign w_hit  = (addr_i >= BaseAddr) && (w_offs < MtimeCtrlOffs + 32'd4);
  assign w_word = w_offs[31:2];

  assign w_sel_mlo  = w_hit && (w_word == MtimeLoOffs[31:2]);
  assign w_sel_mhi  = w_hit && (w_word == MtimeHiOffs[31:2]);
  assign w_sel_clo  = w_hit && (w_word == MtimeCmpLoOffs[31:2]);
  assign w_sel_chi  = w_hit && (w_word == MtimeCmpHiOffs[31:2]);
  assign w_sel_ctrl = w_hit && (w_word == MtimeCtrlOffs[31:2]);

  assign w_wr     = req_i && we_i;
  assign w_rd     = req_i && !we_i;
  assign w_be_any = |be_i;

  // A write to either mtime half suppresses the tick for the full 64 bits.
  assign w_mtime_wr = w_wr && (w_sel_mlo || w_sel_mhi) && w_be_any;
  assign w_ctrl_clr = w_wr && w_sel_ctrl && w_be_any;
  assign w_ctrl_rd  = {r_ctrl.presc, 7'b0, r_ctrl.en};

  zeroheti_mtimer_presc #(
    .PrescW (PrescW)
  ) u_presc (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_en    (r_ctrl.en),
    .i_presc (r_ctrl.presc[PrescW-1:0]),
    .i_clr   (w_ctrl_clr),
    .o_tick  (w_tick)
  );

`ifdef MTIMER_ATOMIC_READ_EN
  logic [31:0] r_shadow;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_shadow <= '0;
    end else if (w_rd && w_sel_mlo) begin
      r_shadow <= r_mtime[63:32];
    end
  end

  assign w_mtime_hi_rd = r_shadow;
`else
  assign w_mtime_hi_rd = r_mtime[63:32];
`endif

  always_comb begin
    w_rdata = '0;
    if (w_sel_mlo)       w_rdata = r_mtime[31:0];
    else if (w_sel_mhi)  w_rdata = w_mtime_hi_rd;
    else if (w_sel_clo)  w_rdata = r_mtimecmp[31:0];
    else if (w_sel_chi)  w_rdata = r_mtimecmp[63:32];
    else if (w_sel_ctrl) w_rdata = w_ctrl_rd;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= req_i;
      r_rdata  <= w_rd ? w_rdata : '0;
      r_err    <= req_i && !w_hit;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_mtime    <= '0;
      r_mtimecmp <= MtimeCmpRst;
      r_ctrl     <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_irq <= r_ctrl.en && (r_mtime >= r_mtimecmp);
      if (w_mtime_wr) begin
        if (w_sel_mlo) r_mtime[31:0]  <= be_merge(r_mtime[31:0], wdata_i, be_i);
        if (w_sel_mhi) r_mtime[63:32] <= be_merge(r_mtime[63:32], wdata_i, be_i);
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end
      if (w_wr && w_sel_clo) r_mtimecmp[31:0]  <= be_merge(r_mtimecmp[31:0], wdata_i, be_i);
      if (w_wr && w_sel_chi) r_mtimecmp[63:32] <= be_merge(r_mtimecmp[63:32], wdata_i, be_i);
      if (w_ctrl_clr) begin
        if (be_i[0]) r_ctrl.en <= wdata_i[0];
        for (int b = 0; b < PrescW; b++) begin
          if (be_i[(8+b)/8]) r_ctrl.presc[b] <= wdata_i[8+b];
        end
      end
    end
  end

  assign rvalid_o    = r_rvalid;
  assign rdata_o     = r_rdata;
  assign err_o       = r_err;
  assign timer_irq_o = r_irq;

endmodule

// File: tb/tb_zeroheti_mtimer.sv
// Bench for zeroheti_mtimer: vector table, directed timing sequences and random
// traffic checked every cycle against a register-level reference model.
module tb_zeroheti_mtimer;

  localparam logic [31:0] BASE = 32'h0000_2100;
  localparam logic [31:0] A_LO = BASE + 32'h00;
  localparam logic [31:0] A_HI = BASE + 32'h04;
  localparam logic [31:0] A_CL = BASE + 32'h08;
  localparam logic [31:0] A_CH = BASE + 32'h0C;
  localparam logic [31:0] A_CT = BASE + 32'h10;

  logic        clk, rst_n, req, gnt, we, rvalid, err, irq;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  zeroheti_mtimer dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .gnt_o       (gnt),
    .addr_i      (addr),
    .we_i        (we),
    .be_i        (be),
    .wdata_i     (wdata),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .err_o       (err),
    .timer_irq_o (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_time, m_cmp;
  logic        m_en;
  logic [7:0]  m_presc, m_cnt;
  logic [31:0] m_shadow;
  logic        e_rvalid, e_err, e_irq;
  logic [31:0] e_rdata;
  logic        mt_tick, mt_hit, mt_wr;
  logic [31:0] mt_idx, mt_ctrl;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] idx);
    case (idx)
      32'd0: return m_time[31:0];
`ifdef MTIMER_ATOMIC_READ_EN
      32'd1: return m_shadow;
`else
      32'd1: return m_time[63:32];
`endif
      32'd2: return m_cmp[31:0];
      32'd3: return m_cmp[63:32];
      32'd4: return {16'h0, m_presc, 7'h0, m_en};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_time = '0; m_cmp = '1; m_en = 1'b0; m_presc = '0; m_cnt = '0; m_shadow = '0;
      e_rvalid = 1'b0; e_err = 1'b0; e_irq = 1'b0; e_rdata = '0;
    end else begin
      mt_tick  = m_en && (m_cnt == m_presc);
      e_irq    = m_en && (m_time >= m_cmp);
      mt_hit   = (addr >= BASE) && ((addr - BASE) < 32'h14);
      mt_idx   = (addr - BASE) >> 2;
      e_rvalid = req;
      e_err    = req && !mt_hit;
      e_rdata  = (req && !we && mt_hit) ? model_read(mt_idx) : 32'h0;
      mt_wr    = req && we && mt_hit && (be != 4'h0);
      if (req && !we && mt_hit && mt_idx == 32'd0) m_shadow = m_time[63:32];
      if (mt_wr && mt_idx == 32'd4) m_cnt = 8'd0;
      else if (m_en) m_cnt = mt_tick ? 8'd0 : m_cnt + 8'd1;
      if (mt_wr && mt_idx == 32'd0)      m_time[31:0]  = merge(m_time[31:0], wdata, be);
      else if (mt_wr && mt_idx == 32'd1) m_time[63:32] = merge(m_time[63:32], wdata, be);
      else if (mt_tick)                  m_time        = m_time + 64'd1;
      if (mt_wr && mt_idx == 32'd2) m_cmp[31:0]  = merge(m_cmp[31:0], wdata, be);
      if (mt_wr && mt_idx == 32'd3) m_cmp[63:32] = merge(m_cmp[63:32], wdata, be);
      if (mt_wr && mt_idx == 32'd4) begin
        mt_ctrl = merge({16'h0, m_presc, 7'h0, m_en}, wdata, be);
        m_en    = mt_ctrl[0];
        m_presc = mt_ctrl[15:8];
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_gnt", gnt, req);
      chk("mon_rvalid", rvalid, e_rvalid);
      chk("mon_rdata", rdata, e_rdata);
      chk("mon_err", err, e_err);
      chk("mon_irq", irq, e_irq);
    end
  end

  // ---------------- bus helpers (entered at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_op(input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d, output logic [31:0] rd, output logic e);
    req = 1'b1; addr = a; we = w; be = b; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; be = 4'h0;
    chk("bus_rvalid", rvalid, 1'b1);
    rd = rdata;
    e  = err;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    logic [31:0] rd;
    logic e;
    bus_op(a, 1'b1, b, d, rd, e);
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] rd);
    logic e;
    bus_op(a, 1'b0, 4'h0, 32'h0, rd, e);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] rd, v1;
    logic        e;
    int          n;
    int          sel;
    logic [31:0] exp_hi;

    vecs[0]  = '{A_LO,        1'b0, 4'h0, 32'h0,         32'h0,         1'b0};
    vecs[1]  = '{A_HI,        1'b0, 4'h0, 32'h0,         32'h0,         1'b0};
    vecs[2]  = '{A_CL,        1'b0, 4'h0, 32'h0,         32'hFFFF_FFFF, 1'b0};
    vecs[3]  = '{A_CH,        1'b0, 4'h0, 32'h0,         32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{A_CT,        1'b0, 4'h0, 32'h0,         32'h0,         1'b0};
    vecs[5]  = '{BASE + 20,   1'b0, 4'h0, 32'h0,         32'h0,         1'b1};
    vecs[6]  = '{BASE - 4,    1'b0, 4'h0, 32'h0,         32'h0,         1'b1};
    vecs[7]  = '{A_CL,        1'b1, 4'h0, 32'h0,         32'h0,         1'b0};
    vecs[8]  = '{A_CL,        1'b0, 4'h0, 32'h0,         32'hFFFF_FFFF, 1'b0};
    vecs[9]  = '{A_CL,        1'b1, 4'h2, 32'h0000_AB00, 32'h0,         1'b0};
    vecs[10] = '{A_CL + 2,    1'b0, 4'h0, 32'h0,         32'hFFFF_ABFF, 1'b0};
    vecs[11] = '{BASE + 20,   1'b1, 4'hF, 32'h0,         32'h0,         1'b1};
    vecs[12] = '{A_CT,        1'b1, 4'hF, 32'hFFFF_FF00, 32'h0,         1'b0};
    vecs[13] = '{A_CT,        1'b0, 4'h0, 32'h0,         32'h0000_FF00, 1'b0};
    vecs[14] = '{A_CT,        1'b1, 4'hF, 32'h0,         32'h0,         1'b0};
    vecs[15] = '{A_CH,        1'b0, 4'h0, 32'h0,         32'hFFFF_FFFF, 1'b0};

    rst_n = 1'b0; req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_irq", irq, 1'b0);

    for (int i = 0; i < 16; i++) begin
      bus_op(vecs[i].addr, vecs[i].we, vecs[i].be, vecs[i].wdata, rd, e);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
    end
    bus_wr(A_CL, 4'hF, 32'hFFFF_FFFF);

    // prescaler 3: one tick every 4 cycles
    bus_wr(A_CT, 4'hF, 32'h0000_0301);
    idle(40);
    bus_rd(A_LO, rd);
    chk("presc_window", (rd >= 32'd9) && (rd <= 32'd11), 1'b1);
    bus_wr(A_CT, 4'hF, 32'h0000_0300);
    bus_rd(A_LO, v1);
    idle(20);
    bus_rd(A_LO, rd);
    chk("presc_hold", rd, m_time[31:0]);
    chk("presc_hold_window", (rd >= 32'd9) && (rd <= 32'd12), 1'b1);

    // carry into high word: exactly two ticks
    bus_wr(A_CT, 4'hF, 32'h0);
    bus_wr(A_HI, 4'hF, 32'h0);
    bus_wr(A_LO, 4'hF, 32'hFFFF_FFFE);
    bus_wr(A_CT, 4'hF, 32'h1);
    idle(1);
    bus_wr(A_CT, 4'hF, 32'h0);
    bus_rd(A_HI, rd); chk("carry_hi", rd, 32'h1);
    bus_rd(A_LO, rd); chk("carry_lo", rd, 32'h0);

    // full 64-bit wrap
    bus_wr(A_HI, 4'hF, 32'hFFFF_FFFF);
    bus_wr(A_LO, 4'hF, 32'hFFFF_FFFE);
    bus_wr(A_CT, 4'hF, 32'h1);
    idle(1);
    bus_wr(A_CT, 4'hF, 32'h0);
    bus_rd(A_HI, rd); chk("wrap_hi", rd, 32'h0);
    bus_rd(A_LO, rd); chk("wrap_lo", rd, 32'h0);

    // interrupt at mtimecmp = 100
    bus_wr(A_CH, 4'hF, 32'h0);
    bus_wr(A_CL, 4'hF, 32'd100);
    bus_wr(A_CT, 4'hF, 32'h1);
    n = 0;
    while (n < 300 && irq !== 1'b1) begin
      idle(1);
      n++;
    end
    chk("irq_latency", n, 101);
    bus_wr(A_CL, 4'hF, 32'd1000);
    chk("irq_still_high", irq, 1'b1);
    idle(1);
    chk("irq_fall", irq, 1'b0);

    // bus write to MTIME_LO collides with a tick
    bus_wr(A_LO, 4'hF, 32'h1234_5678);
    bus_wr(A_CT, 4'hF, 32'h0);
    bus_rd(A_LO, rd); chk("collide_lo", rd, 32'h1234_5679);
    bus_rd(A_HI, rd); chk("collide_hi", rd, 32'h0);

    // LO-then-HI read across a carry
    bus_wr(A_HI, 4'hF, 32'h0);
    bus_wr(A_LO, 4'hF, 32'hFFFF_FFF0);
    bus_wr(A_CT, 4'hF, 32'h1);
    bus_rd(A_LO, rd);
    idle(32);
    bus_rd(A_HI, rd);
`ifdef MTIMER_ATOMIC_READ_EN
    exp_hi = 32'h0;
`else
    exp_hi = 32'h1;
`endif
    chk("atomic_hi", rd, exp_hi);
    bus_wr(A_CT, 4'hF, 32'h0);

    // random back-to-back traffic, one mid-transaction reset
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        rst_n = 1'b0; req = 1'b1; addr = A_LO; we = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; req = 1'b0;
        chk("midrst_rvalid", rvalid, 1'b0);
      end else if ($urandom_range(0, 99) < 25) begin
        req = 1'b0;
        @(posedge clk); #1;
      end else begin
        sel   = $urandom_range(0, 6);
        req   = 1'b1;
        we    = $urandom_range(0, 1) == 1;
        be    = 4'($urandom_range(0, 15));
        addr  = BASE + 32'(sel * 4) + 32'($urandom_range(0, 3));
        if (sel == 6) addr = ($urandom_range(0, 1) == 1) ? BASE - 32'd4 : $urandom;
        case (sel)
          0:       wdata = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom;
          1, 3:    wdata = 32'($urandom_range(0, 1));
          2:       wdata = 32'($urandom_range(0, 300));
          4:       wdata = 32'($urandom_range(0, 3) << 8) | 32'($urandom_range(0, 7) != 0);
          default: wdata = $urandom;
        endcase
        @(posedge clk); #1;
      end
    end
    req = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/zeroheti_mtimer.md
Name: zeroheti_mtimer

Overview:
- Memory-mapped RISC-V machine timer. It is the bus responder that sits behind the MtimerAddr window (0x0000_2100 to 0x0000_2114) of the zeroHETI address map.
- Holds a 64-bit mtime counter with a programmable prescaler and a 64-bit mtimecmp register.
- Drives the core's machine timer interrupt line.
- Bus side is an OBI-style request/grant/rvalid responder with a fixed latency of one cycle.

Parameters:
- BaseAddr, zeroheti_pkg::MtimerAddr.base: window base address; register offsets are relative to it.
- PrescW, 8: prescaler width in bits.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- req_i  in  1  bus request
- gnt_o  out  1  grant; combinationally equal to req_i, so every request is accepted the same cycle
- addr_i  in  32  byte address
- we_i  in  1  write enable
- be_i  in  4  byte enables
- wdata_i  in  32  write data
- rvalid_o  out  1  response valid, asserted exactly 1 cycle after an accepted request
- rdata_o  out  32  read data, valid when rvalid_o=1, 0 otherwise
- err_o  out  1  error response, valid with rvalid_o
- timer_irq_o  out  1  machine timer interrupt, level-sensitive

Behaviour:
- Register map (offset = addr_i - BaseAddr, word aligned, addr_i[1:0] ignored):
  - 0x00 MTIME_LO
  - 0x04 MTIME_HI
  - 0x08 MTIMECMP_LO
  - 0x0C MTIMECMP_HI
  - 0x10 CTRL: bit0 = EN; bits[8+PrescW-1:8] = PRESC; other bits read 0, writes ignored
- Decode errors:
  - Offset at or above 0x14, or addr_i below BaseAddr, gives err_o=1 with rvalid_o and rdata_o=0.
  - An erroring write has no side effects.
- Writes are byte-granular per be_i. be_i=0 is a legal no-op and responds with err_o=0.
- Reset values:
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, prescaler count=0.
  - rvalid_o=0, rdata_o=0, err_o=0, timer_irq_o=0.
- Response pipeline: one stage.
  - Read data is sampled from register state at the accept edge, i.e. the pre-write value if a write lands in the same cycle.
  - Back-to-back requests every cycle are supported.
- Prescaler:
  - Active only when EN=1. The count increments each cycle.
  - When count==PRESC: tick, and count returns to 0.
  - PRESC=0 gives a tick every cycle.
  - On an EN 1->0 transition the count is frozen; it resumes from the frozen value when EN returns to 1.
  - Writing CTRL clears the count.
- mtime increments by 1 on each tick. Full 64-bit wrap from FFFF_FFFF_FFFF_FFFF to 0 with no flag.
- Simultaneous bus write to MTIME_LO or MTIME_HI and a tick: the written bytes take the written value and the tick is dropped for the whole 64-bit value. No carry into the written half.
- Interrupt: registered as timer_irq_o <= EN && (mtime >= mtimecmp), an unsigned 64-bit compare on current register values.
  - Visible 1 cycle after any register change.
  - Stays asserted until mtimecmp is raised, mtime wraps, or EN is cleared.
- Reset mid-transaction: the pending response is discarded; rvalid_o=0 on the cycle after reset.

Optional Feature:
- Macro: MTIMER_ATOMIC_READ_EN.
- With the macro defined:
  - A read of MTIME_LO also latches mtime[63:32] into a 32-bit shadow register.
  - A read of MTIME_HI returns the shadow. The shadow is reset to 0.
  - Gives a tear-free 64-bit read in LO-then-HI order.
- Without the macro: MTIME_HI returns the live mtime[63:32]. No shadow register is present.

Decomposition:
- Add to zeroheti_pkg:
  - offset localparams MtimeLoOffs, MtimeHiOffs, MtimeCmpLoOffs, MtimeCmpHiOffs, MtimeCtrlOffs
  - mtimer_ctrl_t packed struct {presc, en}
  - MtimeCmpRst constant
- Sub-module zeroheti_mtimer_presc contains the prescaler counter, EN gating and tick output. All remaining logic lives in the top module.

Test Plan:
- Reset: read all 5 registers -> MTIME=0, MTIMECMP=FFFF_FFFF_FFFF_FFFF, CTRL=0, timer_irq_o=0, err_o=0.
- Prescaler: write CTRL=0x0000_0301 (PRESC=3, EN=1), wait 40 cycles -> MTIME_LO=10 (±1 at window edge); clear EN -> value holds over 20 further cycles.
- Wrap and carry:
  - Write MTIME_HI=0, MTIME_LO=FFFF_FFFE, PRESC=0, EN=1 -> after 2 ticks read HI=1, LO=0.
  - Also preload FFFF_FFFF_FFFF_FFFF -> wraps to 0.
- Interrupt:
  - MTIMECMP=100, EN=1, PRESC=0 -> timer_irq_o rises 1 cycle after mtime reaches 100.
  - Write MTIMECMP_LO=1000 -> irq falls within 2 cycles.
- Bus edges:
  - Read at BaseAddr+0x14 -> err_o=1, rdata_o=0.
  - Write be_i=4'b0010 wdata=0x0000_AB00 to MTIMECMP_LO -> only byte 1 changes.
  - Write MTIME_LO on the same cycle as a tick -> written value wins.
- Atomic read (with MTIME_ATOMIC... i.e. MTIMER_ATOMIC_READ_EN defined): set mtime=0x0000_0000_FFFF_FFF0, PRESC=0, read LO, wait 32 cycles, read HI -> HI=0. Without the macro, the same sequence returns HI=1.
